// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: qualifies a synchronised lock with a stability window,
// then releases NUM_CLKS domain resets in a staggered order. Optional macro: PLL_SUP_AUTO_RETRY_EN.
module pll_lock_supervisor #(
  parameter int NUM_CLKS            = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SEQ_GAP_CYCLES      = 8
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic [NUM_CLKS-1:0] domain_rst_n,
  output logic                ready,
  output logic [7:0]          relock_count,
  output logic                timeout_err
);

  localparam int RST_W     = $clog2(PLL_RST_CYCLES) + 1;
  localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int GAP_W     = $clog2(SEQ_GAP_CYCLES) + 1;

  localparam logic [RST_W-1:0]     RST_LAST     = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_DONE  = STABLE_W'(LOCK_STABLE_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(SEQ_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t               state;
  logic                 lock_sync_p0;
  logic                 lock_s;
  logic [RST_W-1:0]     rst_cnt;
  logic [STABLE_W-1:0]  stable_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_sync_p0 <= 1'b0;
      lock_s       <= 1'b0;
      state        <= S_RESET_PLL;
      rst_cnt      <= '0;
      stable_cnt   <= '0;
      timeout_cnt  <= '0;
      gap_cnt      <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop lock synchroniser
      lock_sync_p0 <= pll_locked;
      lock_s       <= lock_sync_p0;

      case (state)
        S_RESET_PLL: begin
          pll_rst      <= 1'b1;
          domain_rst_n <= '0;
          ready        <= 1'b0;
          if (rst_cnt == RST_LAST) begin
            state       <= S_WAIT_LOCK;
            pll_rst     <= 1'b0;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // A completed stability window wins over a coincident timeout.
          if (stable_cnt == STABLE_DONE) begin
            state        <= S_RELEASE;
            domain_rst_n <= NUM_CLKS'(1);
            gap_cnt      <= '0;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
`ifdef PLL_SUP_AUTO_RETRY_EN
            state   <= S_RESET_PLL;
            pll_rst <= 1'b1;
            rst_cnt <= '0;
`else
            state   <= S_FAIL;
`endif
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            stable_cnt  <= lock_s ? stable_cnt + 1'b1 : '0;
          end
        end

        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state        <= S_RESET_PLL;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            rst_cnt      <= '0;
            relock_count <= sat_inc8(relock_count);
          end else if (state == S_RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              // Released bits form a thermometer code, so the top bit marks completion.
              if (domain_rst_n[NUM_CLKS-1]) begin
                state <= S_RUN;
                ready <= 1'b1;
              end else begin
                domain_rst_n <= (domain_rst_n << 1) | NUM_CLKS'(1);
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        S_FAIL: begin
          pll_rst      <= 1'b0;
          domain_rst_n <= '0;
          ready        <= 1'b0;
        end

        default: begin
          state <= S_RESET_PLL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomised bench for pll_lock_supervisor, checked against a
// time-stamp based reference model of the supervisor's sequencing rules.
module tb_pll_lock_supervisor;

  localparam int NC = 3;
  localparam int PR = 4;
  localparam int LS = 8;
  localparam int LT = 64;
  localparam int SG = 2;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;
  localparam int M_FAIL = 4;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          pll_rst;
  logic [NC-1:0] domain_rst_n;
  logic          ready;
  logic [7:0]    relock_count;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  int m_mode = M_RST;
  int m_t = 0;
  int m_run = 0;
  int m_relock = 0;
  bit m_err = 1'b0;
  bit h1 = 1'b0;
  bit h2 = 1'b0;

  pll_lock_supervisor #(
    .NUM_CLKS(NC), .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(LT), .SEQ_GAP_CYCLES(SG)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .domain_rst_n(domain_rst_n), .ready(ready), .relock_count(relock_count),
    .timeout_err(timeout_err)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: mode plus elapsed edges in that mode; lock_s is pll_locked delayed two edges.
  task automatic model_edge();
    bit ls;
    if (!rst_n) begin
      m_mode = M_RST; m_t = 0; m_run = 0; m_relock = 0; m_err = 1'b0;
      h1 = 1'b0; h2 = 1'b0;
      return;
    end
    ls = h2; h2 = h1; h1 = pll_locked;
    case (m_mode)
      M_RST: begin
        m_t++;
        if (m_t == PR) begin m_mode = M_WAIT; m_t = 0; m_run = 0; end
      end
      M_WAIT: begin
        if (m_run == LS) begin
          m_mode = M_REL; m_t = 0;
        end else if (m_t + 1 == LT) begin
          m_err = 1'b1;
`ifdef PLL_SUP_AUTO_RETRY_EN
          m_mode = M_RST; m_t = 0;
`else
          m_mode = M_FAIL;
`endif
        end else begin
          m_t++;
          m_run = ls ? m_run + 1 : 0;
        end
      end
      M_REL, M_RUN: begin
        if (!ls) begin
          m_mode = M_RST; m_t = 0;
          if (m_relock < 255) m_relock++;
        end else if (m_mode == M_REL) begin
          m_t++;
          if (m_t == NC * SG) m_mode = M_RUN;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [NC-1:0] exp_dom();
    int k;
    if (m_mode == M_RUN) return '1;
    if (m_mode != M_REL) return '0;
    k = m_t / SG + 1;
    return NC'((1 << k) - 1);
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
    chk("m_pll_rst", pll_rst, (m_mode == M_RST));
    chk("m_domain", domain_rst_n, exp_dom());
    chk("m_ready", ready, (m_mode == M_RUN));
    chk("m_relock", relock_count, m_relock);
    chk("m_timeout", timeout_err, m_err);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    pll_locked = 1'b0;

    // Reset held for 5 cycles
    ticks(5);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_domain", domain_rst_n, 3'b000);
    chk("rst_ready", ready, 0);
    chk("rst_relock", relock_count, 0);
    chk("rst_timeout", timeout_err, 0);

    // pll_rst high for exactly PR cycles after release; clean lock
    rst_n = 1'b1;
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_rst && n < 20);
    chk("pll_rst_len", n, PR);
    ticks(8);
    chk("clean_dom_pre", domain_rst_n, 3'b000);
    tick();
    chk("clean_dom_8", domain_rst_n, 3'b001);
    ticks(2);
    chk("clean_dom_10", domain_rst_n, 3'b011);
    ticks(2);
    chk("clean_dom_12", domain_rst_n, 3'b111);
    tick();
    chk("clean_ready_13", ready, 0);
    tick();
    chk("clean_ready_14", ready, 1);

    // Lock loss in RUN: 3-cycle reaction
    pll_locked = 1'b0;
    ticks(2);
    chk("loss_dom_2", domain_rst_n, 3'b111);
    tick();
    chk("loss_dom_3", domain_rst_n, 3'b000);
    chk("loss_ready", ready, 0);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_relock", relock_count, 1);

    // One-cycle glitch after 5 stable cycles restarts the window
    pll_locked = 1'b1;
    n = 0;
    while (pll_rst && n < 20) begin tick(); n++; end
    chk("glitch_wait_done", (n < 20), 1);
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks(10);
    chk("glitch_dom_pre", domain_rst_n, 3'b000);
    tick();
    chk("glitch_dom_rel", domain_rst_n, 3'b001);
    chk("glitch_timeout", timeout_err, 0);
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    chk("glitch_ready", ready, 1);

    // Repeated lock losses saturate relock_count
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (!domain_rst_n[0] && n < 200) begin tick(); n++; end
      chk("rep_reach_release", (n < 200), 1);
      ticks($urandom_range(0, 9));
      pll_locked = 1'b0;
      ticks(3);
      pll_locked = 1'b1;
    end
    chk("relock_sat", relock_count, 255);

    // Reset asserted mid-RELEASE
    n = 0;
    while (domain_rst_n !== 3'b011 && n < 100) begin tick(); n++; end
    chk("mid_reach_011", domain_rst_n, 3'b011);
    rst_n = 1'b0;
    tick();
    chk("mid_pll_rst", pll_rst, 1);
    chk("mid_domain", domain_rst_n, 3'b000);
    chk("mid_ready", ready, 0);
    chk("mid_relock", relock_count, 0);
    chk("mid_timeout", timeout_err, 0);

    // Timeout with lock held low
    tick();
    rst_n = 1'b1;
    pll_locked = 1'b0;
    ticks(PR);
    chk("to_wait_entry", pll_rst, 0);
    ticks(LT - 1);
    chk("to_before", timeout_err, 0);
    tick();
    chk("to_set", timeout_err, 1);
`ifdef PLL_SUP_AUTO_RETRY_EN
    chk("retry_pll_rst_on", pll_rst, 1);
    ticks(PR - 1);
    chk("retry_pll_rst_hold", pll_rst, 1);
    tick();
    chk("retry_pll_rst_off", pll_rst, 0);
    chk("retry_sticky", timeout_err, 1);
`else
    pll_locked = 1'b1;
    ticks(20);
    chk("fail_pll_rst", pll_rst, 0);
    chk("fail_domain", domain_rst_n, 3'b000);
    chk("fail_ready", ready, 0);
    chk("fail_sticky", timeout_err, 1);
    rst_n = 1'b0;
    tick();
    chk("fail_exit_pll_rst", pll_rst, 1);
    chk("fail_exit_timeout", timeout_err, 0);
    rst_n = 1'b1;
`endif

    // Randomised lock behaviour with long dropouts and rare resets
    for (int i = 0; i < 4000; i++) begin
      if ((i % 500) < 80) pll_locked = ($urandom_range(0, 99) < 10);
      else                pll_locked = ($urandom_range(0, 99) < 95);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised supervisor that sits beside a generated PLL wrapper and runs on the PLL's reference clock. It drives the PLL reset and qualifies the raw `locked` output with a stability window. It then releases NUM_CLKS downstream domain resets in a fixed staggered order. On loss of lock it re-arms the whole sequence, counting relock events, with a bounded wait for lock.

## Interface
Parameters:
- NUM_CLKS, 3: number of output-clock domains sequenced, 1..8.
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt, ≥1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release, ≥1.
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles spent in WAIT_LOCK per attempt, greater than LOCK_STABLE_CYCLES.
- SEQ_GAP_CYCLES, 8: cycles between successive domain reset releases, ≥1.

Ports:
- refclk  in  1  free-running reference clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  raw PLL lock, asynchronous; passes through a 2-flop synchroniser to give `lock_s`.
- pll_rst  out  1  active-high PLL reset.
- domain_rst_n  out  NUM_CLKS  per-domain active-low resets, released index 0 first.
- ready  out  1  all domains released and lock held.
- relock_count  out  8  count of lock-loss events, saturating at 255.
- timeout_err  out  1  sticky; set on any WAIT_LOCK timeout.

## Operation
- Reset values while rst_n=0:
  - pll_rst=1, domain_rst_n=0, ready=0.
  - relock_count=0, timeout_err=0.
  - Synchroniser flops=0, state=RESET_PLL, all counters=0.
- RESET_PLL: pll_rst=1 and all domain_rst_n=0. After PLL_RST_CYCLES cycles, go to WAIT_LOCK with pll_rst=0.
- WAIT_LOCK:
  - The stable counter increments each cycle lock_s=1 and clears on any lock_s=0.
  - The timeout counter increments every cycle.
  - Stable count reaching LOCK_STABLE_CYCLES → RELEASE. This has priority if it coincides with the timeout.
  - Timeout count reaching LOCK_TIMEOUT_CYCLES → timeout_err=1, then the Configuration behaviour applies.
- RELEASE:
  - domain_rst_n[0] rises on entry.
  - Bit i rises i·SEQ_GAP_CYCLES cycles after bit 0.
  - SEQ_GAP_CYCLES after the last bit rises → RUN.
- RUN: ready=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge, all domain_rst_n=0, ready=0, pll_rst=1, and state → RESET_PLL.
  - relock_count increments, saturating at 255.
- relock_count and timeout_err clear only on rst_n.
- rst_n asserted mid-sequence returns every output to its reset value on the same edge, regardless of state.
- All outputs are registered. There is no combinational path from pll_locked to any output.

## Timing
- pll_locked to lock_s: 2 cycles.
- Lock loss (pll_locked falls) to domain resets asserted: 3 cycles.
- For a clean lock, measured from the first edge lock_s=1 in WAIT_LOCK:
  - domain_rst_n[0] rises at +LOCK_STABLE_CYCLES.
  - domain_rst_n[i] rises at +LOCK_STABLE_CYCLES + i·SEQ_GAP_CYCLES.
  - ready rises at +LOCK_STABLE_CYCLES + NUM_CLKS·SEQ_GAP_CYCLES.
- A lock glitch of one or more cycles during WAIT_LOCK restarts the stable window. The timeout counter is not restarted.
- Counter widths are sized with $clog2 of each parameter plus 1. No counter wraps.

## Configuration
- PLL_SUP_AUTO_RETRY_EN defined: a timeout returns to RESET_PLL and the PLL reset is re-applied. Retries are unlimited. A timeout does not change relock_count.
- PLL_SUP_AUTO_RETRY_EN undefined: a timeout enters FAIL.
  - FAIL holds pll_rst=0, domain_rst_n=0 and ready=0.
  - FAIL exits only on rst_n=0.

## Test plan
All scenarios use NUM_CLKS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, SEQ_GAP_CYCLES=2.
- Reset: hold rst_n=0 for 5 cycles → pll_rst=1, domain_rst_n=3'b000, ready=0, relock_count=0. After release, pll_rst stays high for exactly 4 cycles.
- Clean lock: pll_locked steady high from WAIT_LOCK entry → domain_rst_n becomes 001, 011, 111 at lock_s+8, +10 and +12; ready=1 at lock_s+14.
- Glitch: pll_locked drops for 1 cycle after 5 stable cycles → release is delayed until 8 consecutive cycles after the glitch ends; timeout_err stays 0.
- Lock loss in RUN: pll_locked falls → after 3 cycles domain_rst_n=000, ready=0, pll_rst=1 and relock_count=1. After 300 repeated losses, relock_count holds at 255.
- Timeout: pll_locked held at 0 → after 64 WAIT_LOCK cycles timeout_err=1.
  - With PLL_SUP_AUTO_RETRY_EN: pll_rst pulses again for 4 cycles.
  - Without it: the block sits in FAIL with all outputs low until rst_n pulses.
- Reset mid-RELEASE: rst_n=0 when domain_rst_n=011 → all outputs return to their reset values on that edge.
